// File: rtl/top_level_alternative.sv
// Sequential unsigned calculator: add, subtract, multiply, compare with a
// level start / done handshake. Operands are captured on start, the result
// is registered on a 2W-bit output and held until the next operation.
// Build option: define TOP_LEVEL_ALT_FAST_MUL_EN for a single-cycle
// combinational multiplier instead of the default W-cycle shift-add.
module top_level_alternative #(
    parameter int unsigned width = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [width-1:0]     a_i,
    input  logic [width-1:0]     b_i,
    input  logic [1:0]           fct_i,
    output logic [2*width-1:0]   s_o,
    output logic                 signal_o
);

    localparam int unsigned RW = 2 * width;

    localparam logic [1:0] FCT_ADD = 2'b00;
    localparam logic [1:0] FCT_SUB = 2'b01;
    localparam logic [1:0] FCT_MUL = 2'b10;
    localparam logic [1:0] FCT_CMP = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic [1:0]       fct_q, fct_d;
    logic [RW-1:0]    s_q, s_d;
    logic             signal_q, signal_d;

    logic [RW-1:0]    a_ext;
    logic [RW-1:0]    b_ext;
    logic [RW-1:0]    cmp_res;

`ifdef TOP_LEVEL_ALT_FAST_MUL_EN
    logic [width-1:0] op_a_q, op_a_d;
    logic [width-1:0] op_b_q, op_b_d;
    logic [RW-1:0]    mul_res;

    assign a_ext   = {{width{1'b0}}, op_a_q};
    assign mul_res = a_ext * b_ext;
`else
    localparam int unsigned CW = (width > 1) ? $clog2(width) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);

    // Multiplicand is kept 2W wide and shifted left each step; the
    // multiplier shifts right so bit 0 always selects the next partial.
    logic [RW-1:0]    op_a_q, op_a_d;
    logic [width-1:0] op_b_q, op_b_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    mul_sum;

    assign a_ext   = {{width{1'b0}}, op_a_q[width-1:0]};
    assign mul_sum = acc_q + (op_b_q[0] ? op_a_q : '0);
`endif

    assign b_ext = {{width{1'b0}}, op_b_q};

    // Unsigned compare flags: bit0 equal, bit1 greater, bit2 less
    always_comb begin
        cmp_res    = '0;
        cmp_res[0] = (op_a_q[width-1:0] == op_b_q);
        cmp_res[1] = (op_a_q[width-1:0] >  op_b_q);
        cmp_res[2] = (op_a_q[width-1:0] <  op_b_q);
    end

    // Next-state, operand capture and result computation
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        fct_d    = fct_q;
        s_d      = s_q;
        signal_d = 1'b0;
`ifndef TOP_LEVEL_ALT_FAST_MUL_EN
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
`ifdef TOP_LEVEL_ALT_FAST_MUL_EN
                    op_a_d = a_i;
`else
                    op_a_d = {{width{1'b0}}, a_i};
                    acc_d  = '0;
                    cnt_d  = '0;
`endif
                    op_b_d  = b_i;
                    fct_d   = fct_i;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (fct_q)
                    FCT_ADD: begin
                        s_d      = a_ext + b_ext;
                        state_d  = DONE;
                        signal_d = 1'b1;
                    end
                    FCT_SUB: begin
                        s_d      = a_ext - b_ext;
                        state_d  = DONE;
                        signal_d = 1'b1;
                    end
                    FCT_MUL: begin
`ifdef TOP_LEVEL_ALT_FAST_MUL_EN
                        s_d      = mul_res;
                        state_d  = DONE;
                        signal_d = 1'b1;
`else
                        acc_d  = mul_sum;
                        op_a_d = op_a_q << 1;
                        op_b_d = op_b_q >> 1;
                        cnt_d  = cnt_q + 1'b1;
                        // Only the completed product reaches the output
                        if (cnt_q == CNT_LAST) begin
                            s_d      = mul_sum;
                            state_d  = DONE;
                            signal_d = 1'b1;
                        end
`endif
                    end
                    FCT_CMP: begin
                        s_d      = cmp_res;
                        state_d  = DONE;
                        signal_d = 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
            DONE: begin
                // Held start keeps the block parked here; no re-trigger
                signal_d = start_i;
                if (!start_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            fct_q    <= '0;
            s_q      <= '0;
            signal_q <= 1'b0;
`ifndef TOP_LEVEL_ALT_FAST_MUL_EN
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            fct_q    <= fct_d;
            s_q      <= s_d;
            signal_q <= signal_d;
`ifndef TOP_LEVEL_ALT_FAST_MUL_EN
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign s_o      = s_q;
    assign signal_o = signal_q;

endmodule

// File: tb/tb_top_level_alternative.sv
// Directed bench for top_level_alternative (W=8): reset, all four
// functions, latency, handshake hold/drop, operand changes after capture
// and asynchronous reset during a multiply.
module tb_top_level_alternative;

    localparam int unsigned W = 8;
`ifdef TOP_LEVEL_ALT_FAST_MUL_EN
    localparam int unsigned MUL_LAT = 2;
`else
    localparam int unsigned MUL_LAT = W + 1;
`endif
    localparam int unsigned ALU_LAT = 2;

    logic             clock_i = 1'b0;
    logic             reset_i;
    logic             start_i;
    logic [W-1:0]     a_i;
    logic [W-1:0]     b_i;
    logic [1:0]       fct_i;
    logic [2*W-1:0]   s_o;
    logic             signal_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [2*W-1:0] last_s;

    always #5 clock_i = ~clock_i;

    top_level_alternative #(.width(W)) dut (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .fct_i    (fct_i),
        .s_o      (s_o),
        .signal_o (signal_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One full handshake: start, scramble inputs after capture, wait for done,
    // hold start high, then drop it and confirm the result is retained.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] f, input logic [2*W-1:0] exp, input int unsigned lat);
        int unsigned cyc;
        logic        stable;
        @(negedge clock_i);
        a_i = a; b_i = b; fct_i = f; start_i = 1'b1;
        cyc = 0;
        stable = 1'b1;
        do begin
            @(negedge clock_i);
            cyc++;
            if (cyc == 1) begin
                a_i   = ~a;
                b_i   = b ^ 8'h5A;
                fct_i = f + 2'd1;
            end
            if (!signal_o && (s_o !== last_s)) stable = 1'b0;
        end while (!signal_o && cyc < 40);
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_result"}, s_o, exp);
        check({tag, "_no_interm"}, stable, 1);
        repeat (3) @(negedge clock_i);
        check({tag, "_hold_sig"}, signal_o, 1);
        check({tag, "_hold_s"}, s_o, exp);
        start_i = 1'b0;
        @(negedge clock_i);
        check({tag, "_drop_sig"}, signal_o, 0);
        check({tag, "_drop_s"}, s_o, exp);
        last_s = exp;
    endtask

    initial begin
        reset_i = 1'b1;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        fct_i   = 2'b00;
        last_s  = '0;
        repeat (2) @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
        check("reset_s", s_o, 16'h0000);
        check("reset_sig", signal_o, 0);

        // start low in IDLE: nothing happens
        a_i = 8'h12; b_i = 8'h34; fct_i = 2'b00;
        repeat (3) @(negedge clock_i);
        check("idle_s", s_o, 16'h0000);
        check("idle_sig", signal_o, 0);

        run_op("add_aa_55", 8'hAA, 8'h55, 2'b00, 16'h00FF, ALU_LAT);
        run_op("add_carry", 8'hFF, 8'hFF, 2'b00, 16'h01FE, ALU_LAT);
        run_op("sub_aa_55", 8'hAA, 8'h55, 2'b01, 16'h0055, ALU_LAT);
        run_op("sub_55_aa", 8'h55, 8'hAA, 2'b01, 16'hFFAB, ALU_LAT);
        run_op("mul_5_200", 8'd5,  8'd200, 2'b10, 16'h03E8, MUL_LAT);
        run_op("mul_ff_ff", 8'hFF, 8'hFF, 2'b10, 16'hFE01, MUL_LAT);
        run_op("mul_zero",  8'h00, 8'h9C, 2'b10, 16'h0000, MUL_LAT);
        run_op("cmp_eq",    8'h00, 8'h00, 2'b11, 16'h0001, ALU_LAT);
        run_op("cmp_gt",    8'd3,  8'd2,  2'b11, 16'h0002, ALU_LAT);
        run_op("cmp_lt",    8'd2,  8'd3,  2'b11, 16'h0004, ALU_LAT);

        // asynchronous reset in the middle of a multiply
        @(negedge clock_i);
        a_i = 8'd5; b_i = 8'd200; fct_i = 2'b10; start_i = 1'b1;
        repeat (4) @(negedge clock_i);
        #2 reset_i = 1'b1;
        #1;
        check("areset_s", s_o, 16'h0000);
        check("areset_sig", signal_o, 0);
        start_i = 1'b0;
        @(negedge clock_i);
        reset_i = 1'b0;
        repeat (12) @(negedge clock_i);
        check("post_reset_s", s_o, 16'h0000);
        check("post_reset_sig", signal_o, 0);
        last_s = '0;

        run_op("add_recover", 8'd1, 8'd2, 2'b00, 16'h0003, ALU_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top_level_alternative.md
# top_level_alternative

Sequential four-function unsigned calculator (add, subtract, multiply, compare) with a start/done handshake. Operands and function code are captured on start, the result is computed by a small FSM (shift-add multiplier by default), and the result is held on a double-width output with a done flag. Top-level arithmetic block of the calculator design.

## Interface
- `width`, default 8: operand width W (W ≥ 2); result is 2W bits.

One clock; reset is asynchronous and active-high.

- `clock_i`  in  1  system clock, rising edge
- `reset_i`  in  1  asynchronous, active-high reset
- `start_i`  in  1  level start request
- `a_i`  in  W  operand A, unsigned
- `b_i`  in  W  operand B, unsigned
- `fct_i`  in  2  function: 00 add, 01 subtract, 10 multiply, 11 compare
- `s_o`  out  2W  registered result
- `signal_o`  out  1  done flag, registered

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: if `start_i`=1 at a clock edge, latch `a_i`, `b_i` and `fct_i` into internal registers, clear the multiplier accumulator and the counter, then go to EXEC. Otherwise stay in IDLE.
- EXEC, add: `s_o` = zero-extended A + B, carry in bit W.
- EXEC, subtract: `s_o` = A − B as 2W-bit two's complement. Example: 0x55 − 0xAA = 0xFFAB.
- EXEC, compare: `s_o[0]` = (A==B), `s_o[1]` = (A>B), `s_o[2]` = (A<B), all other bits 0. Comparison is unsigned.
- Add, subtract and compare complete in a single EXEC cycle, then go to DONE.
- EXEC, multiply: shift-add, one bit of B per cycle starting at the LSB, for W cycles. `s_o` is written only at the final cycle, then go to DONE. Intermediate values never appear on `s_o`.
- DONE: `signal_o`=1 and `s_o` is held. Stay in DONE while `start_i`=1; go to IDLE when `start_i`=0.
- Holding `start_i` high re-triggers nothing. A new operation requires `start_i` low for at least one cycle, then high again.
- `s_o` keeps its last result through IDLE until the next operation writes it.
- Changes to `a_i`, `b_i` or `fct_i` after capture are ignored until the next start.

## Timing
- Reset (async assert, any state): FSM goes to IDLE, `s_o`=0, `signal_o`=0, internal registers cleared. Reset is released synchronously to the FSM.
- Reset mid-EXEC aborts the operation. No partial result is visible.
- Edge 0 is the edge that samples `start_i`=1 in IDLE.
- Add, subtract, compare: `s_o` is valid and `signal_o` rises after edge 1 (2-cycle latency counting edge 0).
- Multiply: `s_o` is valid and `signal_o` rises after edge W (W+1 cycles latency; 9 cycles for W=8).
- `signal_o` falls on the edge after `start_i` is sampled low in DONE.
- `start_i` sampled low in IDLE: no action.

## Configuration
- `TOP_LEVEL_ALT_FAST_MUL_EN` defined: multiply uses a combinational W×W product written in the single EXEC cycle. Latency is then 2 cycles, the same as add, and the shift-add datapath and counter are omitted.
- Undefined (default): sequential shift-add multiply with W+1 cycles latency as above.
- All other functions are identical in both builds.

## Test plan
- Reset with `reset_i`=1, then release: `s_o`=0x0000 and `signal_o`=0. Asserting reset asynchronously mid-multiply returns the block to IDLE with both outputs 0.
- W=8, A=0xAA, B=0x55, fct=00, `start_i` held: `s_o`=0x00FF and `signal_o`=1 after 2 cycles, both held while start stays high.
- A=0xAA, B=0x55, fct=01: `s_o`=0x0055. Then A=0x55, B=0xAA: `s_o`=0xFFAB.
- A=5, B=200, fct=10: `s_o`=0x03E8, `signal_o` high exactly 9 cycles after edge 0 (2 cycles with the macro defined). A=0xFF, B=0xFF gives 0xFE01.
- fct=11 with A=B=0: `s_o`=0x0001. A=3, B=2: 0x0002. A=2, B=3: 0x0004.
- Handshake: change operands while in EXEC and DONE → result unchanged. Drop `start_i` → `signal_o`=0 next cycle and `s_o` held. Raise `start_i` again → new operation runs.
